cbus_arbiter_rr: RTL and testbench
==================================

# cbus_arbiter_rr

N-input cache-bus arbiter that merges the per-master CBus channels (instruction-cache, data-cache, uncached paths, …) into the single CBus port leaving the CPU top. Generalises the fixed two-input mux: parametrised input count, selectable fixed-priority or round-robin policy, and optional built-in kseg0/kseg1 address translation on the outgoing request. Each transaction is locked to its master from grant until the last response beat.

## Interface
- `NUM_INPUTS`, 2: number of CBus masters (2..8).
- `RR_EN_POLICY`, 1: 1 = round-robin, 0 = fixed priority (index 0 highest).
- `clk` in 1: clock.
- `resetn` in 1: synchronous, active-low reset.
- `ireqs` in `NUM_INPUTS` x `cbus_req_t`: master requests; index 0 is `ireqs[0]`.
- `iresps` out `NUM_INPUTS` x `cbus_resp_t`: per-master responses.
- `oreq` out `cbus_req_t`: request to memory side.
- `oresp` in `cbus_resp_t`: response from memory side (`ready`, `last`, `data`).

## Operation
- Two states: IDLE, BUSY. Registered `sel` (clog2(`NUM_INPUTS`) bits), registered `ptr` (round-robin start index).
- IDLE: `oreq` all-zero (`valid`=0), all `iresps` zero. If any `ireqs[i].valid`, choose winner:
  - fixed: lowest index with valid.
  - round-robin: first valid scanning `ptr`, `ptr+1`, … modulo `NUM_INPUTS`.
  - Register `sel` = winner, go BUSY.
- BUSY: `oreq` = `ireqs[sel]` (with address translation if enabled); `iresps[sel]` = `oresp`; all other `iresps` zero. Non-selected masters' `valid` ignored and held off (they see `ready`=0).
- Exit BUSY when `oresp.ready && oresp.last`: go IDLE; round-robin sets `ptr` = (`sel`+1) mod `NUM_INPUTS`; fixed leaves `ptr` at 0.
- Selected master dropping `valid` before last beat is a protocol violation; arbiter keeps forwarding, does not release.
- `NUM_INPUTS` not a power of two: wrap via explicit compare, never index beyond `NUM_INPUTS-1`.

## Timing
- Reset (`resetn`=0 at a rising edge): state IDLE, `sel`=0, `ptr`=0; `oreq` and all `iresps` zero from the following cycle. Reset mid-transaction aborts it; no response completes.
- Grant latency: valid seen in IDLE at cycle t → `oreq.valid` at t+1.
- Response path combinational: `oresp` → `iresps[sel]` same cycle.
- Last beat at cycle t → IDLE at t+1 (`oreq.valid`=0, one bubble) → next winner forwarded at t+2.
- Simultaneous requests: exactly one granted; others wait, never lost while they hold `valid`.
- Single-beat transaction (`len`=0): `ready`+`last` same cycle, same rules.

## Configuration
- `ARBITER_ADDR_TRANS_EN` defined: `oreq.addr` translated; addresses 0x8000_0000–0xBFFF_FFFF (kseg0/kseg1) map to `addr & 0x1FFF_FFFF`; all other addresses pass unchanged. Other request fields unchanged.
- Not defined: `oreq.addr` = `ireqs[sel].addr` exactly; no translation logic instantiated.

## Test plan
- Reset: hold `resetn`=0 with all inputs valid → `oreq.valid`=0, all `iresps.ready`=0; release → grant to index 0 one cycle later.
- Single master: `ireqs[1]` read, `len`=3, addr 0x1FC0_0000; slave gives 4 ready beats, last on 4th → `iresps[1]` sees 4 beats, `iresps[0]` zero, IDLE next cycle.
- Round-robin, `NUM_INPUTS`=3, all valid continuously, single-beat transactions → grant order 0,1,2,0,1 with one idle cycle between each.
- Fixed priority, inputs 0 and 2 continuously valid → only 0 ever granted; 2 granted once 0 deasserts.
- Lock: during `ireqs[1]` 8-beat burst, `ireqs[0]` asserts valid → `iresps[0].ready` stays 0 until burst last beat; 0 granted two cycles after last.
- `ARBITER_ADDR_TRANS_EN` defined: request addr 0xBFC0_0010 → `oreq.addr`=0x1FC0_0010; addr 0x0000_1000 → unchanged; undefined → 0xBFC0_0010 passes through.

Source files
------------

// File: rtl/cbus_arbiter_rr.sv
// cbus_arbiter_rr: N-input CBus arbiter, fixed-priority or round-robin, transaction locked until last beat.
// Define ARBITER_ADDR_TRANS_EN to fold kseg0/kseg1 addresses onto physical space on the outgoing request.
package cbus_arbiter_rr_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

module cbus_arbiter_rr
  import cbus_arbiter_rr_pkg::*;
#(
  parameter int NUM_INPUTS   = 2,
  parameter int RR_EN_POLICY = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  ireqs  [NUM_INPUTS],
  output cbus_resp_t iresps [NUM_INPUTS],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);
  localparam int SW = $clog2(NUM_INPUTS);
  localparam logic [SW:0] N_W = (SW+1)'(NUM_INPUTS);
  localparam logic [SW-1:0] LAST = SW'(NUM_INPUTS - 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [SW-1:0] sel, ptr, win;
  logic [SW:0] idx;
  logic found;
  // scan starts at ptr; fixed priority keeps ptr at 0, so one scanner serves both policies
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      idx = {1'b0, ptr} + (SW+1)'(k);
      idx = (idx >= N_W) ? idx - N_W : idx;
      if (!found && ireqs[idx[SW-1:0]].valid) begin
        found = 1'b1;
        win = idx[SW-1:0];
      end
    end
  end
  always_comb begin
    oreq = '0;
    for (int i = 0; i < NUM_INPUTS; i++) iresps[i] = '0;
    if (state == BUSY) begin
      oreq = ireqs[sel];
`ifdef ARBITER_ADDR_TRANS_EN
      oreq.addr = (ireqs[sel].addr[31:30] == 2'b10) ? (ireqs[sel].addr & 32'h1FFF_FFFF) : ireqs[sel].addr;
`endif
      iresps[sel] = oresp;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      sel <= '0;
      ptr <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        state <= BUSY;
        sel <= win;
      end
    end else if (oresp.ready && oresp.last) begin
      state <= IDLE;
      ptr <= (RR_EN_POLICY != 0 && sel != LAST) ? sel + 1'b1 : '0;
    end
  end
endmodule

// File: tb/tb_cbus_arbiter_rr.sv
// tb_cbus_arbiter_rr: round-robin and fixed-priority arbiters on shared stimulus, checked against a queue-free ownership model.
module tb_cbus_arbiter_rr;
  import cbus_arbiter_rr_pkg::*;
  localparam int N = 3;
`ifdef ARBITER_ADDR_TRANS_EN
  localparam logic [31:0] EXP_K = 32'h1FC0_0010;
`else
  localparam logic [31:0] EXP_K = 32'hBFC0_0010;
`endif
  logic clk = 1'b0;
  logic resetn;
  cbus_req_t req [N];
  cbus_resp_t rsp_rr [N];
  cbus_resp_t rsp_fp [N];
  cbus_req_t oreq_rr, oreq_fp;
  cbus_resp_t oresp;
  int checks = 0;
  int errors = 0;
  int own_rr = -1, own_fp = -1, ptr_rr = 0;
  bit armed = 1'b0;
  int order [5] = '{0, 1, 2, 0, 1};

  always #5 clk = ~clk;

  cbus_arbiter_rr #(.NUM_INPUTS(N), .RR_EN_POLICY(1)) dut (
    .clk(clk), .resetn(resetn), .ireqs(req), .iresps(rsp_rr), .oreq(oreq_rr), .oresp(oresp));
  cbus_arbiter_rr #(.NUM_INPUTS(N), .RR_EN_POLICY(0)) dut_fp (
    .clk(clk), .resetn(resetn), .ireqs(req), .iresps(rsp_fp), .oreq(oreq_fp), .oresp(oresp));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] a_of(input int i);
    return 32'h1000 * (i + 1);
  endfunction

  function automatic logic [31:0] xl(input logic [31:0] a);
`ifdef ARBITER_ADDR_TRANS_EN
    return (a >= 32'h8000_0000 && a <= 32'hBFFF_FFFF) ? (a & 32'h1FFF_FFFF) : a;
`else
    return a;
`endif
  endfunction

  function automatic int pick(input int p);
    for (int k = 0; k < N; k++)
      if (req[(p + k) % N].valid) return (p + k) % N;
    return -1;
  endfunction

  function automatic cbus_req_t exp_req(input int own);
    cbus_req_t r;
    if (own < 0) return '0;
    r = req[own];
    r.addr = xl(r.addr);
    return r;
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      armed = 1'b1;
      own_rr = -1;
      own_fp = -1;
      ptr_rr = 0;
    end else begin
      if (own_rr < 0) own_rr = pick(ptr_rr);
      else if (oresp.ready && oresp.last) begin
        ptr_rr = (own_rr + 1) % N;
        own_rr = -1;
      end
      if (own_fp < 0) own_fp = pick(0);
      else if (oresp.ready && oresp.last) own_fp = -1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("model_oreq_rr", oreq_rr, exp_req(own_rr));
      chk("model_oreq_fp", oreq_fp, exp_req(own_fp));
      for (int i = 0; i < N; i++) begin
        chk("model_iresp_rr", rsp_rr[i], (i == own_rr) ? oresp : '0);
        chk("model_iresp_fp", rsp_fp[i], (i == own_fp) ? oresp : '0);
      end
    end
  end

  initial begin
    resetn = 1'b0;
    oresp = '{ready: 1'b1, last: 1'b1, data: 32'hA5};
    for (int i = 0; i < N; i++) begin
      req[i] = '0;
      req[i].valid = 1'b1;
      req[i].addr = a_of(i);
      req[i].data = 32'hC0 + i;
    end
    step();
    step();
    @(negedge clk);
    chk("rst_oreq_valid", oreq_rr.valid, 1'b0);
    for (int i = 0; i < N; i++) chk("rst_iresp_ready", rsp_rr[i].ready, 1'b0);
    resetn = 1'b1;
    step();
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      chk("rr_grant_valid", oreq_rr.valid, 1'b1);
      chk("rr_grant_addr", oreq_rr.addr, a_of(order[g]));
      chk("rr_grant_ready", rsp_rr[order[g]].ready, 1'b1);
      chk("fp_grant_addr", oreq_fp.addr, a_of(0));
      step();
      @(negedge clk);
      chk("rr_bubble", oreq_rr.valid, 1'b0);
      step();
    end
    req[1].valid = 1'b0;
    step();
    step();
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("fp_only0", oreq_fp.addr, a_of(0));
      step();
      step();
    end
    step();
    req[0].valid = 1'b0;
    step();
    @(negedge clk);
    chk("fp_then2", oreq_fp.addr, a_of(2));
    req[2].valid = 1'b0;
    step();
    req[1] = '0;
    req[1].valid = 1'b1;
    req[1].addr = 32'h1FC0_0000;
    req[1].len = 4'd3;
    oresp = '0;
    step();
    @(negedge clk);
    chk("sm_addr", oreq_rr.addr, 32'h1FC0_0000);
    for (int b = 0; b < 4; b++) begin
      oresp = '{ready: 1'b1, last: (b == 3), data: 32'hD0 + b};
      @(negedge clk);
      chk("sm_beat_ready", rsp_rr[1].ready, 1'b1);
      chk("sm_beat_data", rsp_rr[1].data, 32'hD0 + b);
      chk("sm_other_zero", rsp_rr[0], '0);
      step();
    end
    req[1].valid = 1'b0;
    oresp = '0;
    @(negedge clk);
    chk("sm_idle", oreq_rr.valid, 1'b0);
    req[1].valid = 1'b1;
    req[1].addr = 32'hBFC0_0010;
    req[1].len = 4'd7;
    step();
    req[0].valid = 1'b1;
    for (int b = 0; b < 8; b++) begin
      oresp = '{ready: 1'b1, last: (b == 7), data: 32'hE0 + b};
      @(negedge clk);
      chk("lock_ready0", rsp_rr[0].ready, 1'b0);
      chk("lock_addr", oreq_rr.addr, EXP_K);
      step();
    end
    req[1].valid = 1'b0;
    oresp = '0;
    @(negedge clk);
    chk("lock_bubble", oreq_rr.valid, 1'b0);
    step();
    @(negedge clk);
    chk("lock_next_valid", oreq_rr.valid, 1'b1);
    chk("lock_next_addr", oreq_rr.addr, a_of(0));
    oresp = '{ready: 1'b1, last: 1'b0, data: 32'h77};
    resetn = 1'b0;
    step();
    @(negedge clk);
    chk("midrst_valid", oreq_rr.valid, 1'b0);
    chk("midrst_ready", rsp_rr[0].ready, 1'b0);
    resetn = 1'b1;
    for (int i = 0; i < N; i++) req[i].valid = 1'b0;
    oresp = '0;
    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
